// File: rtl/tri_test_sequencer_if.sv
// Handshake and ROM bus between the triangle test sequencer,
// the geometry ROM and the result consumer.
interface tri_test_sequencer_if #(
  parameter int ADDR_W  = 5,
  parameter int COORD_W = 12
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic [ADDR_W-1:0]         tri_addr;
  logic [ADDR_W-1:0]         pt_addr;
  logic signed [COORD_W-1:0] p1x;
  logic signed [COORD_W-1:0] p1y;
  logic signed [COORD_W-1:0] p2x;
  logic signed [COORD_W-1:0] p2y;
  logic signed [COORD_W-1:0] p3x;
  logic signed [COORD_W-1:0] p3y;
  logic signed [COORD_W-1:0] ptx;
  logic signed [COORD_W-1:0] pty;
  logic                      res_valid;
  logic                      res_ready;
  logic                      res_inside;
  logic [ADDR_W-1:0]         res_tri;
  logic [ADDR_W-1:0]         res_pt;

  modport master (
    output start, p1x, p1y, p2x, p2y, p3x, p3y,
    output ptx, pty, res_ready,
    input  busy, done, tri_addr, pt_addr,
    input  res_valid, res_inside, res_tri, res_pt
  );

  modport slave (
    input  start, p1x, p1y, p2x, p2y, p3x, p3y,
    input  ptx, pty, res_ready,
    output busy, done, tri_addr, pt_addr,
    output res_valid, res_inside, res_tri, res_pt
  );
endinterface

// File: rtl/tri_test_sequencer.sv
// Point-in-triangle scan over a ROM of triangles x points,
// one shared edge-sign unit used for three edges in turn.
module tri_test_sequencer #(
  parameter int N_TRI   = 3,
  parameter int N_PT    = 6,
  parameter int COORD_W = 12,
  parameter int ADDR_W  = 5
) (
  input logic               clk,
  input logic               rst_n,
  tri_test_sequencer_if.slave bus
);
  localparam int PW = 2 * COORD_W;
  localparam logic [ADDR_W-1:0] LAST_PT  = ADDR_W'(N_PT - 1);
  localparam logic [ADDR_W-1:0] LAST_TRI = ADDR_W'(N_TRI - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FT, S_LT, S_FP, S_LP,
    S_E0, S_E1, S_E2, S_EM, S_DN
  } state_t;

  state_t r_state;

  logic signed [COORD_W-1:0] r_p1x, r_p1y;
  logic signed [COORD_W-1:0] r_p2x, r_p2y;
  logic signed [COORD_W-1:0] r_p3x, r_p3y;
  logic signed [COORD_W-1:0] r_ptx, r_pty;
  logic                      r_s0, r_s1;
  logic                      r_busy, r_done;
  logic                      r_valid, r_inside;
  logic [ADDR_W-1:0]         r_tri_addr, r_pt_addr;
  logic [ADDR_W-1:0]         r_res_tri, r_res_pt;

  logic signed [COORD_W-1:0] w_ax, w_ay, w_bx, w_by;
  logic signed [COORD_W-1:0] w_d1, w_d2, w_d3, w_d4;
  logic signed [PW-1:0]      w_m1, w_m2;
  logic                      w_s;

  // Edge operand select: (p1,p2) in E0, (p2,p3) in E1, (p3,p1) in E2
  always_comb begin
    w_ax = r_p1x;
    w_ay = r_p1y;
    w_bx = r_p2x;
    w_by = r_p2y;
    unique case (r_state)
      S_E1: begin
        w_ax = r_p2x;
        w_ay = r_p2y;
        w_bx = r_p3x;
        w_by = r_p3y;
      end
      S_E2: begin
        w_ax = r_p3x;
        w_ay = r_p3y;
        w_bx = r_p1x;
        w_by = r_p1y;
      end
      default: ;
    endcase
  end

  assign w_d1 = r_ptx - w_bx;
  assign w_d2 = w_ay - w_by;
  assign w_d3 = w_ax - w_bx;
  assign w_d4 = r_pty - w_by;
  assign w_m1 = PW'(w_d1) * PW'(w_d2);
  assign w_m2 = PW'(w_d3) * PW'(w_d4);
  assign w_s  = w_m1 < w_m2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_inside   <= 1'b0;
      r_tri_addr <= '0;
      r_pt_addr  <= '0;
      r_res_tri  <= '0;
      r_res_pt   <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_p1x      <= '0;
      r_p1y      <= '0;
      r_p2x      <= '0;
      r_p2y      <= '0;
      r_p3x      <= '0;
      r_p3y      <= '0;
      r_ptx      <= '0;
      r_pty      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_FT;
            r_busy     <= 1'b1;
            r_tri_addr <= '0;
            r_pt_addr  <= '0;
          end
        end
        S_FT: r_state <= S_LT;
        S_LT: begin
          r_p1x   <= bus.p1x;
          r_p1y   <= bus.p1y;
          r_p2x   <= bus.p2x;
          r_p2y   <= bus.p2y;
          r_p3x   <= bus.p3x;
          r_p3y   <= bus.p3y;
          r_state <= S_FP;
        end
        S_FP: r_state <= S_LP;
        S_LP: begin
          r_ptx   <= bus.ptx;
          r_pty   <= bus.pty;
          r_state <= S_E0;
        end
        S_E0: begin
          r_s0    <= w_s;
          r_state <= S_E1;
        end
        S_E1: begin
          r_s1    <= w_s;
          r_state <= S_E2;
        end
        S_E2: begin
          r_valid   <= 1'b1;
          r_inside  <= (r_s0 == r_s1) && (r_s1 == w_s);
          r_res_tri <= r_tri_addr;
          r_res_pt  <= r_pt_addr;
          r_state   <= S_EM;
        end
        S_EM: begin
          if (bus.res_ready) begin
            r_valid <= 1'b0;
            if (r_pt_addr != LAST_PT) begin
              r_pt_addr <= r_pt_addr + 1'b1;
              r_state   <= S_FP;
            end else if (r_tri_addr != LAST_TRI) begin
              r_tri_addr <= r_tri_addr + 1'b1;
              r_pt_addr  <= '0;
              r_state    <= S_FT;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DN;
            end
          end
        end
        S_DN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.tri_addr   = r_tri_addr;
  assign bus.pt_addr    = r_pt_addr;
  assign bus.res_valid  = r_valid;
  assign bus.res_inside = r_inside;
  assign bus.res_tri    = r_res_tri;
  assign bus.res_pt     = r_res_pt;
endmodule

// File: tb/tb_tri_test_sequencer.sv
// Bench for tri_test_sequencer: synchronous ROM model, scan-level
// reference model checked every cycle, plus literal pins.
module tb_tri_test_sequencer;
  localparam int N_TRI = 3;
  localparam int N_PT  = 6;
  localparam int CW    = 12;
  localparam int AW    = 5;
  localparam int N_RES = N_TRI * N_PT;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tri_test_sequencer_if #(.ADDR_W(AW), .COORD_W(CW)) bus ();

  tri_test_sequencer #(
    .N_TRI(N_TRI), .N_PT(N_PT), .COORD_W(CW), .ADDR_W(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tri_rom [N_TRI][6] = '{
    '{23, 79, 15, 68, 36, 94},
    '{-500, -500, 500, -500, 0, 500},
    '{2000, 2000, -2000, 0, 0, -2000}
  };
  int pt_rom [N_PT][2] = '{
    '{23, 79}, '{84, 72}, '{24, 80},
    '{-100, 50}, '{2000, -2000}, '{0, 0}
  };

  always @(posedge clk) begin
    bus.p1x <= CW'(tri_rom[bus.tri_addr][0]);
    bus.p1y <= CW'(tri_rom[bus.tri_addr][1]);
    bus.p2x <= CW'(tri_rom[bus.tri_addr][2]);
    bus.p2y <= CW'(tri_rom[bus.tri_addr][3]);
    bus.p3x <= CW'(tri_rom[bus.tri_addr][4]);
    bus.p3y <= CW'(tri_rom[bus.tri_addr][5]);
    bus.ptx <= CW'(pt_rom[bus.pt_addr][0]);
    bus.pty <= CW'(pt_rom[bus.pt_addr][1]);
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;
  int rdy_mode = 0;
  int bp_cnt = 0;
  bit exp_in [N_RES];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic int w12(input int v);
    logic signed [CW-1:0] t;
    t = CW'(v);
    return int'(t);
  endfunction

  // Sign of the cross product of (a-b) and (pt-b), coordinates wrapped
  function automatic bit edge_s(input int px, input int py,
                                input int ax, input int ay,
                                input int bx, input int by);
    longint cr;
    cr = longint'(w12(ax - bx)) * longint'(w12(py - by))
       - longint'(w12(px - bx)) * longint'(w12(ay - by));
    return cr > 0;
  endfunction

  function automatic bit inside_of(input int t, input int p);
    bit s0, s1, s2;
    int px, py;
    px = pt_rom[p][0];
    py = pt_rom[p][1];
    s0 = edge_s(px, py, tri_rom[t][0], tri_rom[t][1],
                tri_rom[t][2], tri_rom[t][3]);
    s1 = edge_s(px, py, tri_rom[t][2], tri_rom[t][3],
                tri_rom[t][4], tri_rom[t][5]);
    s2 = edge_s(px, py, tri_rom[t][4], tri_rom[t][5],
                tri_rom[t][0], tri_rom[t][1]);
    return (s0 == s1) && (s1 == s2);
  endfunction

  initial begin
    for (int t = 0; t < N_TRI; t++)
      for (int p = 0; p < N_PT; p++)
        exp_in[t*N_PT + p] = inside_of(t, p);
  end

  // Scan-level reference: counts cycles to each result, walks the list
  initial begin
    bit m_active, m_valid, m_done, m_after_rst;
    int m_wait, m_idx;
    m_active = 0; m_valid = 0; m_done = 0;
    m_after_rst = 1; m_wait = 0; m_idx = 0;
    forever begin
      @(negedge clk);
      chk("busy", 32'(bus.busy), 32'(m_active));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
      if (bus.done === 1'b1) n_done++;
      if (m_valid) begin
        chk("res_tri", 32'(bus.res_tri), 32'(m_idx / N_PT));
        chk("res_pt", 32'(bus.res_pt), 32'(m_idx % N_PT));
        chk("res_inside", 32'(bus.res_inside), 32'(exp_in[m_idx]));
        chk("tri_addr held", 32'(bus.tri_addr), 32'(m_idx / N_PT));
        chk("pt_addr held", 32'(bus.pt_addr), 32'(m_idx % N_PT));
      end
      if (m_after_rst) begin
        chk("rst tri_addr", 32'(bus.tri_addr), 0);
        chk("rst pt_addr", 32'(bus.pt_addr), 0);
        chk("rst res_tri", 32'(bus.res_tri), 0);
        chk("rst res_pt", 32'(bus.res_pt), 0);
        chk("rst res_inside", 32'(bus.res_inside), 0);
      end
      if (bus.res_valid === 1'b1 && bus.res_tri == 0) begin
        if (bus.res_pt == 0) chk("T2 vertex", 32'(bus.res_inside), 1);
        if (bus.res_pt == 1) chk("T3 outside", 32'(bus.res_inside), 0);
        if (bus.res_pt == 2) chk("near vertex", 32'(bus.res_inside), 1);
      end
      m_after_rst = 0;
      if (!rst_n) begin
        m_active = 0; m_valid = 0; m_done = 0;
        m_wait = 0; m_idx = 0; m_after_rst = 1;
      end else if (m_done) begin
        m_done = 0;
        m_active = 0;
      end else if (!m_active) begin
        if (bus.start) begin
          m_active = 1;
          m_wait = 7;
          m_idx = 0;
        end
      end else if (m_valid) begin
        if (bus.res_ready) begin
          m_valid = 0;
          if (m_idx == N_RES - 1) begin
            m_done = 1;
          end else begin
            m_idx++;
            m_wait = (m_idx % N_PT == 0) ? 7 : 5;
          end
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_valid = 1;
      end
    end
  end

  // Consumer ready policy
  initial begin
    int cyc;
    cyc = 0;
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      case (rdy_mode)
        1: begin
          if (bus.res_valid && bus.res_tri == 1 &&
              bus.res_pt == 3 && bp_cnt < 10) begin
            bus.res_ready = 1'b0;
            bp_cnt++;
          end else begin
            bus.res_ready = 1'b1;
          end
        end
        2: bus.res_ready = (cyc % 3 != 0);
        default: bus.res_ready = 1'b1;
      endcase
    end
  end

  task automatic wait_done(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      #2;
      if (bus.done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_done timeout", 0, 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // Scan 1: backpressure at (1,3), stray starts mid-scan and in DN
    rdy_mode = 1;
    pulse_start();
    repeat (20) @(posedge clk);
    #2 bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #2 bus.start = 1'b0;
    wait_done(1000, ok);
    bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("T5 backpressure cycles", 32'(bp_cnt), 10);

    // Scan 2: toggling ready, then reset mid-scan
    rdy_mode = 2;
    pulse_start();
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    // Scan 3: full speed to completion
    rdy_mode = 0;
    pulse_start();
    wait_done(1000, ok);
    repeat (6) @(posedge clk);
    #2;
    chk("done pulses", 32'(n_done), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
